data_memory_ws: RTL and testbench

Parametrised single-port data memory with byte-enable writes, a valid/ready request handshake, a programmable wait-state count and registered responses. It replaces the fixed 32-bit, always-ready data memory on the processor's load/store path, so the core can be tested against slower memories. It also flags out-of-range or misaligned accesses instead of silently aliasing them.

---
 rtl/data_memory_ws_pkg.sv | 24 ++
 rtl/data_memory_ws_if.sv | 25 ++
 rtl/data_memory_ws_mem_array.sv | 31 +++
 rtl/data_memory_ws.sv | 108 ++++++++++
 tb/tb_data_memory_ws.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_ws_pkg.sv
// Shared types and helpers for the wait-state data memory.
// FSM encoding, a constant-safe log2 and the idle response values.
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Ceiling log2; usable in localparam expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  localparam int   RESP_DATA_DEFAULT = 0;
  localparam logic RESP_ERR_DEFAULT  = 1'b0;

endpackage

// File: rtl/data_memory_ws_if.sv
// Request/response bus of the wait-state data memory.
// The master issues requests; the slave (memory) returns one response each.
interface data_memory_ws_if #(
  parameter int WIDTH = 32
);
  logic               reqValid;
  logic               reqReady;
  logic               writeEnable;
  logic [WIDTH/8-1:0] byteEnable;
  logic [31:0]        address;
  logic [WIDTH-1:0]   dataIn;
  logic               respValid;
  logic [WIDTH-1:0]   dataOut;
  logic               addrError;

  modport master (
    output reqValid, writeEnable, byteEnable, address, dataIn,
    input  reqReady, respValid, dataOut, addrError
  );

  modport slave (
    input  reqValid, writeEnable, byteEnable, address, dataIn,
    output reqReady, respValid, dataOut, addrError
  );
endinterface

// File: rtl/data_memory_ws_mem_array.sv
// Word-organised storage with byte-masked synchronous write and registered read.
// Not reset: contents persist across resets.
module mem_array
  import data_memory_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                      clk,
  input  logic [clog2(DEPTH)-1:0]   wordIndex,
  input  logic [WIDTH/8-1:0]        byteEnable,
  input  logic                      writeStrobe,
  input  logic [WIDTH-1:0]          dataIn,
  output logic [WIDTH-1:0]          dataOut
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read-before-write: a commit edge never mixes a read with a write.
  always_ff @(posedge clk) begin
    if (writeStrobe) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (byteEnable[b]) begin
          mem_q[wordIndex][b*8 +: 8] <= dataIn[b*8 +: 8];
        end
      end
    end
    dataOut <= mem_q[wordIndex];
  end

endmodule

// File: rtl/data_memory_ws.sv
// Single-port data memory with valid/ready requests, programmable wait states
// and a one-cycle registered response that flags misaligned/out-of-range accesses.
module data_memory_ws
  import data_memory_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int WAITSTATES = 2
) (
  input  logic           clk,
  input  logic           resetN,
  data_memory_ws_if.slave bus
);

  localparam int          NBYTES      = WIDTH / 8;
  localparam int          BYTEBITS    = clog2(NBYTES);
  localparam int          IDXBITS     = clog2(DEPTH);
  localparam logic [31:0] ALIGN_MASK  = 32'((64'd1 << BYTEBITS) - 64'd1);
  localparam logic [31:0] INDEX_SPAN  = 32'((64'd1 << (BYTEBITS + IDXBITS)) - 64'd1);
  localparam logic [3:0]  CNT_INIT    = 4'((WAITSTATES > 0) ? WAITSTATES - 1 : 0);
  localparam bit          LIVE_COMMIT = (WAITSTATES == 0);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [NBYTES-1:0]   be_q;
  logic [31:0]         addr_q;
  logic [WIDTH-1:0]    din_q;
  logic                rd_ok_q;
  logic                err_q;

  logic                accept;
  logic                commit;
  logic                c_we;
  logic                c_ok;
  logic [NBYTES-1:0]   c_be;
  logic [31:0]         c_addr;
  logic [WIDTH-1:0]    c_din;
  logic [IDXBITS-1:0]  c_idx;
  logic [WIDTH-1:0]    rdata;

  assign bus.reqReady = resetN && (state_q != WAIT);
  assign accept       = bus.reqValid && bus.reqReady;

  // With no wait states the commit uses the live request on the accept edge.
  assign c_we   = LIVE_COMMIT ? bus.writeEnable : we_q;
  assign c_be   = LIVE_COMMIT ? bus.byteEnable  : be_q;
  assign c_addr = LIVE_COMMIT ? bus.address     : addr_q;
  assign c_din  = LIVE_COMMIT ? bus.dataIn      : din_q;
  assign commit = LIVE_COMMIT ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));

  assign c_ok  = ((c_addr & ALIGN_MASK) == 32'd0) && ((c_addr & ~INDEX_SPAN) == 32'd0);
  assign c_idx = c_addr[BYTEBITS +: IDXBITS];

  mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk         (clk),
    .wordIndex   (c_idx),
    .byteEnable  (c_be),
    .writeStrobe (commit && c_we && c_ok),
    .dataIn      (c_din),
    .dataOut     (rdata)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rd_ok_q <= 1'b0;
      err_q   <= RESP_ERR_DEFAULT;
    end else begin
      rd_ok_q <= commit && c_ok && !c_we;
      err_q   <= commit && !c_ok;
      if (accept) begin
        we_q   <= bus.writeEnable;
        be_q   <= bus.byteEnable;
        addr_q <= bus.address;
        din_q  <= bus.dataIn;
      end
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            state_q <= LIVE_COMMIT ? RESP : WAIT;
            cnt_q   <= CNT_INIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.respValid = (state_q == RESP);
  assign bus.dataOut   = rd_ok_q ? rdata : WIDTH'(RESP_DATA_DEFAULT);
  assign bus.addrError = err_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboard bench: two memories (2 wait states and 0 wait states) driven with
// directed and random requests, checked against an array model of the memory.
module tb_data_memory_ws;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int NW    = 32;
  localparam int WS0   = 2;
  localparam int WS1   = 0;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  data_memory_ws_if #(.WIDTH(WIDTH)) b0 ();
  data_memory_ws_if #(.WIDTH(WIDTH)) b1 ();

  data_memory_ws #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAITSTATES(WS0)) dut0 (
    .clk(clk), .resetN(resetN), .bus(b0)
  );
  data_memory_ws #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAITSTATES(WS1)) dut1 (
    .clk(clk), .resetN(resetN), .bus(b1)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][NW];
  int          nresp [2];

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(DEPTH * 4));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon_one(input int d, input logic rv, input logic [31:0] dout, input logic err);
    exp_t e;
    int   qs;
    if (rv === 1'b1) begin
      nresp[d]++;
      qs = (d == 0) ? q0.size() : q1.size();
      check($sformatf("resp_pending%0d", d), 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("dataOut%0d", d), dout, e.data);
        check($sformatf("addrError%0d", d), 32'(err), 32'(e.err));
        check($sformatf("latency%0d", d), 32'(cyc), 32'(e.cyc));
        $display("[TB] dut%0d resp data=%h err=%0b cycle=%0d", d, dout, err, cyc);
      end
    end else begin
      check($sformatf("idle_dataOut%0d", d), dout, 32'd0);
      check($sformatf("idle_addrError%0d", d), 32'(err), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      mon_one(0, b0.respValid, b0.dataOut, b0.addrError);
      mon_one(1, b1.respValid, b1.dataOut, b1.addrError);
    end
  end

  task automatic drive(input int d, input bit v, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] data);
    if (d == 0) begin
      b0.reqValid = v; b0.writeEnable = we; b0.byteEnable = be; b0.address = addr; b0.dataIn = data;
    end else begin
      b1.reqValid = v; b1.writeEnable = we; b1.byteEnable = be; b1.address = addr; b1.dataIn = data;
    end
  endtask

  // Present a request until accepted; track=0 means the response is not expected.
  task automatic issue(input int d, input bit we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] data, input bit track, output int acc);
    int   n;
    int   idx;
    bit   rdy;
    exp_t e;
    n = 0;
    @(negedge clk);
    drive(d, 1'b1, we, be, addr, data);
    rdy = (d == 0) ? b0.reqReady : b1.reqReady;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      rdy = (d == 0) ? b0.reqReady : b1.reqReady;
    end
    if (!rdy) begin
      check($sformatf("accept_timeout%0d", d), 32'(rdy), 32'd1);
      drive(d, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      acc = -1;
      return;
    end
    acc = cyc;
    if (track) begin
      idx    = int'(addr >> 2);
      e.err  = !addr_ok(addr);
      e.cyc  = cyc + ((d == 0) ? WS0 : WS1) + 1;
      e.data = 32'd0;
      if (addr_ok(addr) && idx >= NW) $fatal(1, "FAIL stimulus: address %h outside modelled range", addr);
      if (addr_ok(addr) && !we) e.data = model[d][idx];
      if (addr_ok(addr) && we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[d][idx][8*b +: 8] = data[8*b +: 8];
        end
      end
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic rand_op(input int d);
    int          w;
    int          r;
    int          acc;
    logic [31:0] addr;
    w    = int'($urandom_range(0, NW - 1));
    r    = int'($urandom_range(0, 99));
    addr = 32'(w * 4);
    if (r < 10)      addr = addr + 32'($urandom_range(1, 3));
    else if (r < 15) addr = 32'(DEPTH * 4) + addr;
    else if (r < 18) addr = 32'h8000_0000 | addr;
    issue(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), addr, $urandom, 1'b1, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_reqReady"},  32'(b0.reqReady),  32'd0);
    check({tag, "_respValid"}, 32'(b0.respValid), 32'd0);
    check({tag, "_dataOut"},   b0.dataOut,        32'd0);
    check({tag, "_addrError"}, 32'(b0.addrError), 32'd0);
  endtask

  initial begin
    int a1, a2, n0;
    int ab [4];
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    nresp[0] = 0;
    nresp[1] = 0;

    repeat (3) @(negedge clk);
    check_quiet("rst");
    check("rst_reqReady1", 32'(b1.reqReady), 32'd0);
    check("rst_respValid1", 32'(b1.respValid), 32'd0);
    @(posedge clk);
    #1 resetN = 1'b1;
    @(negedge clk);
    check("rel_reqReady0", 32'(b0.reqReady), 32'd1);
    check("rel_reqReady1", 32'(b1.reqReady), 32'd1);

    for (int w = 0; w < NW; w++) issue(0, 1'b1, 4'hF, 32'(w * 4), $urandom, 1'b1, a1);
    for (int w = 0; w < NW; w++) issue(1, 1'b1, 4'hF, 32'(w * 4), $urandom, 1'b1, a1);

    // Directed: full write/read, partial write, misaligned and out-of-range.
    issue(0, 1'b1, 4'hF, 32'd0, 32'd42, 1'b1, a1);
    issue(0, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1, a2);
    check("accept_in_resp", 32'(a2), 32'(a1 + WS0 + 1));
    issue(0, 1'b1, 4'hF, 32'd4, 32'h1234_5678, 1'b1, a1);
    issue(0, 1'b1, 4'h1, 32'd4, 32'h0000_00AB, 1'b1, a1);
    issue(0, 1'b0, 4'hF, 32'd4, 32'd0, 1'b1, a1);
    issue(0, 1'b1, 4'hF, 32'd1, 32'd48, 1'b1, a1);
    issue(0, 1'b1, 4'hF, 32'd4, 32'd48, 1'b1, a1);
    issue(0, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1, a1);
    issue(0, 1'b0, 4'hF, 32'd4096, 32'd0, 1'b1, a1);

    drain();
    n0 = nresp[0];
    repeat (10) @(negedge clk);
    check("idle_no_resp", 32'(nresp[0]), 32'(n0));
    issue(0, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1, a1);
    issue(0, 1'b0, 4'hF, 32'd4, 32'd0, 1'b1, a1);

    // Reset during WAIT discards the pending write of 99.
    drain();
    issue(0, 1'b1, 4'hF, 32'd8, 32'd99, 1'b0, a1);
    @(negedge clk);
    resetN = 1'b0;
    #1 check_quiet("rstwait_a");
    @(negedge clk);
    check_quiet("rstwait_b");
    @(posedge clk);
    #1 resetN = 1'b1;
    issue(0, 1'b0, 4'hF, 32'd8, 32'd0, 1'b1, a1);

    for (int i = 0; i < 150; i++) rand_op(0);
    drain();

    // Zero wait states, back-to-back reads.
    for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'hF, 32'(i * 4), 32'd0, 1'b1, ab[i]);
    for (int i = 1; i < 4; i++) check($sformatf("b2b_accept%0d", i), 32'(ab[i]), 32'(ab[0] + i));
    for (int i = 0; i < 100; i++) rand_op(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
